// File: rtl/tinv_pkg.sv
// tinv_pkg: shared state encoding and counter limits for tinv bus/mux controllers
package tinv_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
  localparam int DEAD_MAX = 15;
  localparam int CNT_W = 8;
endpackage

// File: rtl/tinv_rr_pick.sv
// tinv_rr_pick: combinational round-robin pick of the first set req bit after ptr, wrapping
module tinv_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] k;
  // Scan farthest-first so the nearest set bit after ptr is the last one written
  always_comb begin
    found = 1'b0;
    idx = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) begin
        found = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/tinv_bus_ctrl.sv
// tinv_bus_ctrl: round-robin en/enb sequencer for N tinv drivers sharing one bus,
// with break-before-make dead time and optional hold-time preemption
module tinv_bus_ctrl
  import tinv_pkg::*;
#(
  parameter int N = 4,
  parameter int DEAD = 2,
  parameter int MAX_HOLD = 0,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          VDD,
  input  logic          VSS,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  en,
  output logic [N-1:0]  enb,
  output logic [IW-1:0] gnt_idx,
  output logic          busy,
  output logic          turn
);
  if (N < 2 || N > 16) begin : g_bad_n
    $error("tinv_bus_ctrl: N must be 2..16");
  end
  if (DEAD < 1 || DEAD > DEAD_MAX) begin : g_bad_dead
    $error("tinv_bus_ctrl: DEAD must be 1..%0d", DEAD_MAX);
  end
  if (MAX_HOLD < 0 || MAX_HOLD >= 2 ** CNT_W) begin : g_bad_hold
    $error("tinv_bus_ctrl: MAX_HOLD out of range");
  end
  localparam logic [N-1:0] ONE = N'(1);
  localparam logic [CNT_W-1:0] DEAD_C = CNT_W'(DEAD);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  state_t state, state_n;
  logic [N-1:0] en_q, en_n;
  logic [IW-1:0] gnt_q, gnt_n, ptr_q, ptr_n, pick;
  logic [CNT_W-1:0] hold_q, hold_n, dcnt_q, dcnt_n;
  logic turn_q, turn_n, busy_q, busy_n;
  logic found, rel, go, supply_ok;
  tinv_rr_pick #(.N(N)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .found(found),
    .idx  (pick)
  );
  always_comb begin
    state_n = state;
    en_n = en_q;
    gnt_n = gnt_q;
    ptr_n = ptr_q;
    hold_n = hold_q;
    dcnt_n = dcnt_q;
    turn_n = turn_q;
    rel = 1'b0;
    go = found && (state == IDLE || (state == TURN && dcnt_q == CNT_W'(1)));
    case (state)
      DRIVE: begin
        hold_n = (hold_q < HOLD_MAX) ? hold_q + 1'b1 : hold_q;
        rel = !req[gnt_q] || (MAX_HOLD != 0 && hold_q == HOLD_LAST && |(req & ~en_q));
        if (rel) begin
          en_n = '0;
          turn_n = 1'b1;
          dcnt_n = DEAD_C;
          state_n = TURN;
        end
      end
      TURN: begin
        dcnt_n = dcnt_q - 1'b1;
        if (dcnt_q == CNT_W'(1)) begin
          turn_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // IDLE and the last dead cycle share one arbitration path straight into DRIVE
    if (go) begin
      en_n = ONE << pick;
      gnt_n = pick;
      ptr_n = pick;
      hold_n = '0;
      turn_n = 1'b0;
      state_n = DRIVE;
    end
    busy_n = |en_n;
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      en_q <= '0;
      gnt_q <= '0;
      ptr_q <= IW'(N - 1);
      hold_q <= '0;
      dcnt_q <= '0;
      turn_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state <= state_n;
      en_q <= en_n;
      gnt_q <= gnt_n;
      ptr_q <= ptr_n;
      hold_q <= hold_n;
      dcnt_q <= dcnt_n;
      turn_q <= turn_n;
      busy_q <= busy_n;
    end
  end
  // Invalid supplies poison the cell controls without touching internal state
  assign supply_ok = (VDD === 1'b1) && (VSS === 1'b0);
  assign en = supply_ok ? en_q : 'x;
  assign enb = supply_ok ? ~en_q : 'x;
  assign gnt_idx = gnt_q;
  assign busy = busy_q;
  assign turn = turn_q;
  a_onehot: assert property (@(posedge clk) disable iff (!rstb) $onehot0(en_q));
  a_bbm: assert property (@(posedge clk) disable iff (!rstb)
    (en_q != '0 && $past(en_q) != '0) |-> en_q == $past(en_q));
endmodule

// File: tb/tb_tinv_bus_ctrl.sv
// tb_tinv_bus_ctrl: directed stimulus with a grant/release scoreboard for tinv_bus_ctrl
module tb_tinv_bus_ctrl;
  localparam int N = 4;
  localparam int DEAD = 2;
  localparam int MAX_HOLD = 3;
  localparam int IW = 2;
  typedef struct {
    bit             rel;
    logic [N-1:0]   en;
    logic [IW-1:0]  gnt;
    int             cyc;
  } ev_t;
  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic vdd = 1'b1;
  logic vss = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] en, enb;
  logic [IW-1:0] gnt_idx;
  logic busy, turn;
  int passed = 0;
  int total = 0;
  bit mon_on = 1'b0;
  ev_t exp_q[$];
  logic [N-1:0] prev_en = '0;
  int high_run = 0;
  int zero_run = 0;
  logic [N-1:0] rot_en[4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
  int rot_idx[4] = '{3, 0, 1, 2};

  tinv_bus_ctrl #(.N(N), .DEAD(DEAD), .MAX_HOLD(MAX_HOLD)) dut (
    .clk    (clk),
    .rstb   (rstb),
    .VDD    (vdd),
    .VSS    (vss),
    .req    (req),
    .en     (en),
    .enb    (enb),
    .gnt_idx(gnt_idx),
    .busy   (busy),
    .turn   (turn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_grant(input logic [N-1:0] e, input int g, input int gap);
    exp_q.push_back(ev_t'{1'b0, e, IW'(g), gap});
  endtask

  task automatic push_rel(input int cyc);
    exp_q.push_back(ev_t'{1'b1, '0, '0, cyc});
  endtask

  task automatic wait_en(input logic [N-1:0] v, input int lim);
    int n = 0;
    while (en !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_en", en, v);
  endtask

  // Monitor: pops one expected event per grant or release seen on en
  always @(negedge clk) begin
    ev_t ev;
    logic [N-1:0] inv;
    if (mon_on) begin
      inv = ~en;
      chk("enb_inv", enb, inv);
      chk("busy_tracks_en", busy, |en);
      chk("onehot0", $onehot0(en), 1);
      if (en != prev_en) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_event: got en=%b with nothing expected", en);
        end else begin
          ev = exp_q.pop_front();
          chk("event_en", en, ev.rel ? '0 : ev.en);
          if (!ev.rel) begin
            chk("grant_idx", gnt_idx, ev.gnt);
            if (ev.cyc >= 0) chk("dead_cycles", prev_en != '0 ? 0 : zero_run, ev.cyc);
          end else if (ev.cyc >= 0) begin
            chk("hold_cycles", high_run, ev.cyc);
          end
        end
        high_run = (en != '0) ? 1 : 0;
        zero_run = (en == '0) ? 1 : 0;
      end else if (en != '0) begin
        high_run++;
      end else begin
        zero_run++;
      end
      prev_en = en;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    req = 4'b0101;
    repeat (2) @(negedge clk);
    chk("rst_en", en, 4'b0000);
    chk("rst_enb", enb, 4'b1111);
    chk("rst_gnt", gnt_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_turn", turn, 0);
    push_grant(4'b0001, 0, -1);
    rstb = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("first_en", en, 4'b0001);
    chk("first_gnt", gnt_idx, 0);
    chk("first_busy", busy, 1);
    // owner 0 drops with req[2] waiting
    push_rel(1);
    push_grant(4'b0100, 2, DEAD);
    req = 4'b0100;
    repeat (DEAD) begin
      @(negedge clk);
      chk("gap_en", en, 4'b0000);
      chk("gap_turn", turn, 1);
    end
    @(negedge clk);
    chk("second_en", en, 4'b0100);
    chk("second_gnt", gnt_idx, 2);
    chk("second_turn", turn, 0);
    // all requesting: preemption rotates 2 -> 3 -> 0 -> 1 -> 2
    req = 4'b1111;
    push_rel(MAX_HOLD);
    for (int i = 0; i < 4; i++) begin
      push_grant(rot_en[i], rot_idx[i], DEAD);
      if (i < 3) push_rel(MAX_HOLD);
    end
    wait_en(4'b0010, 40);
    wait_en(4'b0100, 20);
    // single requester 1 keeps the bus indefinitely
    push_rel(1);
    push_grant(4'b0010, 1, DEAD);
    req = 4'b0010;
    wait_en(4'b0010, 10);
    repeat (8) begin
      @(negedge clk);
      chk("solo_en", en, 4'b0010);
      chk("solo_turn", turn, 0);
    end
    // asynchronous reset between edges
    push_rel(-1);
    #2;
    rstb = 1'b0;
    req = 4'b1010;
    #1;
    chk("async_en", en, 4'b0000);
    chk("async_enb", enb, 4'b1111);
    chk("async_busy", busy, 0);
    push_grant(4'b0010, 1, -1);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    chk("restart_en", en, 4'b0010);
    chk("restart_gnt", gnt_idx, 1);
    req = 4'b0010;
    // supply loss during DRIVE
    @(negedge clk);
    mon_on = 1'b0;
    vdd = 1'b0;
    #1;
    chk("nosupply_en", (^en === 1'bx) || (en == enb), 1);
    chk("nosupply_gnt", gnt_idx, 1);
    chk("nosupply_busy", busy, 1);
    repeat (3) @(negedge clk);
    vdd = 1'b1;
    #1;
    chk("restore_en", en, 4'b0010);
    chk("restore_enb", enb, 4'b1101);
    vss = 1'b1;
    #1;
    chk("badvss_en", (^en === 1'bx) || (en == enb), 1);
    vss = 1'b0;
    #1;
    chk("restore2_en", en, 4'b0010);
    @(negedge clk);
    mon_on = 1'b1;
    // everyone leaves: dead time then IDLE
    push_rel(-1);
    req = 4'b0000;
    repeat (DEAD + 2) @(negedge clk);
    chk("idle_en", en, 4'b0000);
    chk("idle_turn", turn, 0);
    chk("idle_busy", busy, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
